// File: rtl/valid_ready_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, synchronous flush and occupancy count.
// Latency DEPTH-1 edges after accept; the ready chain is combinational, so a full pipe still accepts when out_ready=1.
module valid_ready_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q,  data_d;
    logic [CW-1:0]               count_q, count_d;
    logic [DEPTH-1:0]            take;
    logic                        xfer_in, xfer_out;

    // take[i]: stage i may be written this cycle (it is empty or its word moves on)
    always_comb begin
        take = '0;
        take[DEPTH-1] = out_ready | ~valid_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            take[i] = ~valid_q[i] | take[i+1];
        end
    end

    assign in_ready  = take[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (take[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (take[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        // flush drops every word but leaves the data registers untouched
        if (flush) begin
            valid_d = '0;
            data_d  = data_q;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (xfer_in && !xfer_out) begin
            count_d = count_q + CW'(1);
        end else if (!xfer_in && xfer_out) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= {DEPTH{RESET_VAL}};
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_valid_ready_pipe.sv
// Randomised and directed bench for valid_ready_pipe; words are tracked by stage position in a queue.
module tb_valid_ready_pipe;

    localparam int DEPTH = 3;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;

    int         pos_q[$];
    logic [7:0] exp_q[$];
    int         new_pos[$];
    logic       p_ov, p_ir, p_emit, p_acc;

    valid_ready_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'hA5)) dut (
        .clock(clock), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .count(count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each word holds a stage index; it moves up one stage unless the word ahead blocks it.
    task automatic predict();
        int lim;
        int np;
        new_pos.delete();
        p_ov   = !flush && pos_q.size() > 0 && pos_q[0] == DEPTH - 1;
        p_emit = p_ov && out_ready;
        lim    = DEPTH - 1;
        foreach (pos_q[j]) begin
            if (j == 0 && p_emit) continue;
            np = (pos_q[j] + 1 < lim) ? pos_q[j] + 1 : lim;
            new_pos.push_back(np);
            lim = np - 1;
        end
        p_ir  = !flush && (new_pos.size() == 0 || new_pos[new_pos.size()-1] >= 1);
        p_acc = in_valid && p_ir;
    endtask

    // Starts and ends just after a rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clock);
        predict();
        chk("in_ready", 32'(in_ready), 32'(p_ir));
        chk("out_valid", 32'(out_valid), 32'(p_ov));
        chk("count", 32'(count), 32'(pos_q.size()));
        @(posedge clock);
        if (flush) begin
            pos_q.delete();
            exp_q.delete();
        end else begin
            pos_q = new_pos;
            if (p_acc) begin
                pos_q.push_back(0);
                exp_q.push_back(in_data);
            end
        end
        #1;
    endtask

    // Monitor: every word the DUT hands over must be the oldest outstanding one.
    always @(negedge clock) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_data: unexpected word %0h with nothing outstanding at %0t", out_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %0h expected %0h at %0t", out_data, e, $time);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;

        // reset hold and release
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'hA5);
        chk("rst count", 32'(count), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // streaming
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        chk("stream peak count", 32'(count), 32'd3);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // backpressure, then full pipe accepting and emitting on the same edge
        for (int k = 1; k <= 4; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        chk("bp full count", 32'(count), 32'd3);
        cycle(1'b1, 8'h04, 1'b1, 1'b0);
        chk("bp count held", 32'(count), 32'd3);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // bubble collapse
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble count", 32'(count), 32'd2);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // flush with a word offered
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1, 1'b1);
        chk("flush count", 32'(count), 32'd0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // asynchronous reset between edges
        cycle(1'b1, 8'hD1, 1'b0, 1'b0);
        cycle(1'b1, 8'hD2, 1'b0, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst count", 32'(count), 32'd0);
        pos_q.delete();
        exp_q.delete();
        @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end

        repeat (DEPTH + 3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
